// File: rtl/note_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | note_sequencer: 16-step programmable melody controller, one-hot buzzer out  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module note_sequencer #(
  parameter int TICK_DIV   = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  input  logic [3:0] seq_len,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] buzzer,
  output logic       busy,
  output logic [3:0] step_idx,
  output logic       done,
  output logic       wr_err
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      step_q, step_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [3:0]      dur_q, dur_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [7:0]      buzzer_q, buzzer_d;
  logic            done_q, done_d;
  logic            wr_err_q, wr_err_d;
  logic [7:0]      mem_q [16];
  logic [7:0]      mem_d [16];

  logic            tick;
  logic            advance;
  logic [3:0]      last_step;
  logic [3:0]      cur_dur;
  logic [7:0]      nxt;

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    pre_d     = pre_q;
    dur_d     = dur_q;
    gap_d     = gap_q;
    done_d    = 1'b0;
    wr_err_d  = wr_en && (state_q != S_IDLE);
    advance   = 1'b0;
    mem_d     = mem_q;
    tick      = (pre_q == PRE_LAST);
    cur_dur   = mem_q[step_q][3:0];
    last_step = (seq_len == 4'd0) ? 4'd15 : seq_len - 4'd1;

    // The program port is only open while idle
    if (wr_en && (state_q == S_IDLE)) begin
      mem_d[wr_addr] = wr_data;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_PLAY;
          step_d  = 4'd0;
          pre_d   = '0;
          dur_d   = 4'd0;
        end
      end
      S_PLAY: begin
        if (stop) begin
          state_d = S_IDLE;
          step_d  = 4'd0;
        end else if (tick) begin
          pre_d = '0;
          if (dur_q == cur_dur) begin
            if (GAP_CYCLES > 0) begin
              state_d = S_GAP;
              gap_d   = '0;
            end else begin
              advance = 1'b1;
            end
          end else begin
            dur_d = dur_q + 4'd1;
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      S_GAP: begin
        if (stop) begin
          state_d = S_IDLE;
          step_d  = 4'd0;
        end else if (gap_q == GAP_LAST) begin
          advance = 1'b1;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        step_d  = 4'd0;
      end
    endcase

    // A seq_len that shrank below the current step makes this the last step
    if (advance) begin
      pre_d = '0;
      dur_d = 4'd0;
      if (step_q < last_step) begin
        step_d  = step_q + 4'd1;
        state_d = S_PLAY;
      end else if (loop_en) begin
        step_d  = 4'd0;
        state_d = S_PLAY;
      end else begin
        step_d  = 4'd0;
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end

    // Buzzer is registered alongside the state, so it looks ahead at the
    // entry about to play (including a same-edge write to it)
    nxt      = mem_d[step_d];
    buzzer_d = ((state_d == S_PLAY) && !nxt[7]) ? (8'h01 << nxt[6:4]) : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      step_q   <= 4'd0;
      pre_q    <= '0;
      dur_q    <= 4'd0;
      gap_q    <= '0;
      buzzer_q <= 8'h00;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= 8'h80;
      end
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      pre_q    <= pre_d;
      dur_q    <= dur_d;
      gap_q    <= gap_d;
      buzzer_q <= buzzer_d;
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
      mem_q    <= mem_d;
    end
  end

  assign buzzer   = buzzer_q;
  assign busy     = (state_q != S_IDLE);
  assign step_idx = step_q;
  assign done     = done_q;
  assign wr_err   = wr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_note_sequencer: randomized and directed bench for note_sequencer         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_note_sequencer;

  localparam int TICK = 4;
  localparam int GAP  = 2;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       loop_en;
  logic [3:0] seq_len;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] buzzer;
  logic       busy;
  logic [3:0] step_idx;
  logic       done;
  logic       wr_err;

  // {buzzer, busy, step_idx, done, wr_err}
  logic [14:0] obs;
  logic [14:0] exp_q [$];
  logic [7:0]  ref_mem [16];
  int          total;
  int          bad;

  note_sequencer #(.TICK_DIV(TICK), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .seq_len(seq_len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .buzzer(buzzer), .busy(busy), .step_idx(step_idx), .done(done), .wr_err(wr_err)
  );

  assign obs = {buzzer, busy, step_idx, done, wr_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected per-cycle output list for one playback, starting the cycle after start
  task automatic build_trace(input int len, input bit lp, input int passes);
    logic [7:0] e;
    logic [7:0] bz;
    logic [3:0] s4;
    int         d;
    exp_q.delete();
    for (int p = 0; p < passes; p++) begin
      for (int s = 0; s < len; s++) begin
        e  = ref_mem[s];
        bz = e[7] ? 8'h00 : (8'h01 << e[6:4]);
        d  = int'(e[3:0]);
        s4 = s[3:0];
        for (int c = 0; c < (d + 1) * TICK; c++) exp_q.push_back({bz, 1'b1, s4, 2'b00});
        for (int c = 0; c < GAP; c++) exp_q.push_back({8'h00, 1'b1, s4, 2'b00});
      end
    end
    if (!lp) exp_q.push_back({8'h00, 1'b0, 4'h0, 1'b1, 1'b0});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h80;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic write_mem(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    ref_mem[a] = d;
    total++;
    if (wr_err !== 1'b0) begin
      bad++;
      $display("FAIL idle_write_err addr=%0d got=%b required=0", a, wr_err);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    total++;
    if (obs !== 15'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h required=0", obs);
    end
    do_reset();
    total++;
    if (obs !== 15'h0) begin
      bad++;
      $display("FAIL after_reset_idle got=%h required=0", obs);
    end
  endtask

  task automatic test_single();
    write_mem(4'd0, 8'h31);
    seq_len = 4'd1; loop_en = 1'b0;
    build_trace(1, 1'b0, 1);
    pulse_start();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) tick();
      total++;
      if (obs !== exp_q[i]) begin
        bad++;
        $display("FAIL single[%0d] got=%h required=%h", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_three();
    write_mem(4'd0, 8'h00);
    write_mem(4'd1, 8'h80);
    write_mem(4'd2, 8'h72);
    seq_len = 4'd3; loop_en = 1'b0;
    build_trace(3, 1'b0, 1);
    pulse_start();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) tick();
      total++;
      if (obs !== exp_q[i]) begin
        bad++;
        $display("FAIL three[%0d] got=%h required=%h", i, obs, exp_q[i]);
      end
    end
    // Shrink seq_len during step 1: step 1 becomes the last step
    tick();
    build_trace(2, 1'b0, 1);
    pulse_start();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) tick();
      total++;
      if (obs !== exp_q[i]) begin
        bad++;
        $display("FAIL shrink[%0d] got=%h required=%h", i, obs, exp_q[i]);
      end
      if (i == 8) seq_len = 4'd1;
    end
    seq_len = 4'd3;
  endtask

  task automatic test_loop_stop();
    loop_en = 1'b1; seq_len = 4'd3;
    build_trace(3, 1'b1, 2);
    pulse_start();
    for (int i = 0; i <= 32; i++) begin
      if (i > 0) tick();
      total++;
      if (obs !== exp_q[i]) begin
        bad++;
        $display("FAIL loop[%0d] got=%h required=%h", i, obs, exp_q[i]);
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs !== 15'h0) begin
        bad++;
        $display("FAIL stop_idle[%0d] got=%h required=0", i, obs);
      end
      tick();
    end
    loop_en = 1'b0;
  endtask

  task automatic test_wr_err();
    logic [14:0] t;
    seq_len = 4'd3; loop_en = 1'b0;
    build_trace(3, 1'b0, 1);
    t = exp_q[3];
    t[0] = 1'b1;
    exp_q[3] = t;
    pulse_start();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) tick();
      total++;
      if (obs !== exp_q[i]) begin
        bad++;
        $display("FAIL busy_write[%0d] got=%h required=%h", i, obs, exp_q[i]);
      end
      if (i == 2) begin wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h55; end
      if (i == 3) wr_en = 1'b0;
    end
    tick();
    build_trace(3, 1'b0, 1);
    pulse_start();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) tick();
      total++;
      if (obs !== exp_q[i]) begin
        bad++;
        $display("FAIL replay[%0d] got=%h required=%h", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_start_stop_seqlen0();
    start = 1'b1; stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (obs !== 15'h0) begin
        bad++;
        $display("FAIL start_stop_idle[%0d] got=%h required=0", i, obs);
      end
    end
    start = 1'b0; stop = 1'b0;
    do_reset();
    seq_len = 4'd0; loop_en = 1'b0;
    build_trace(16, 1'b0, 1);
    pulse_start();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) tick();
      total++;
      if (obs !== exp_q[i]) begin
        bad++;
        $display("FAIL len16[%0d] got=%h required=%h", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    write_mem(4'd0, 8'h31);
    seq_len = 4'd1; loop_en = 1'b0;
    pulse_start();
    tick();
    tick();
    total++;
    if (buzzer !== 8'h08) begin
      bad++;
      $display("FAIL pre_reset_buzzer got=%h required=08", buzzer);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 15'h0) begin
      bad++;
      $display("FAIL async_reset got=%h required=0", obs);
    end
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h80;
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (obs !== 15'h0) begin
      bad++;
      $display("FAIL post_reset_no_done got=%h required=0", obs);
    end
    seq_len = 4'd2;
    build_trace(2, 1'b0, 1);
    pulse_start();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) tick();
      total++;
      if (obs !== exp_q[i]) begin
        bad++;
        $display("FAIL silent[%0d] got=%h required=%h", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int len;
    for (int it = 0; it < 8; it++) begin
      len = int'($urandom_range(1, 6));
      for (int s = 0; s < len; s++) begin
        write_mem(4'(s), {1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          4'($urandom_range(0, 3))});
      end
      seq_len = 4'(len); loop_en = 1'b0;
      build_trace(len, 1'b0, 1);
      pulse_start();
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) tick();
        total++;
        if (obs !== exp_q[i]) begin
          bad++;
          $display("FAIL rand%0d[%0d] got=%h required=%h", it, i, obs, exp_q[i]);
        end
      end
      tick();
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0; seq_len = 4'd0;
    wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'h00;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h80;
    test_reset();
    test_single();
    tick();
    test_three();
    tick();
    test_loop_stop();
    test_wr_err();
    tick();
    test_start_stop_seqlen0();
    tick();
    test_async_reset();
    tick();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
